// File: rtl/mccoy_prog_feeder.sv
// mccoy_prog_feeder: a small program store that a host loads with 6-bit
// instruction words. After `start` it serves those words to a core, one
// registered fetch per cycle, indexed by the core's program counter.
//
// Optional feature: define MCCOY_FEEDER_BKPT_EN to add the bkpt_addr and
// bkpt_en ports. A breakpoint hit in RUN suppresses that fetch and moves
// the feeder to HALT. Without the macro, halted is tied low and HALT is
// never entered.
module mccoy_prog_feeder #(
  parameter int          DEPTH = 16,
  parameter logic [5:0]  FILL  = 6'b000000,
  localparam int         AW    = $clog2(DEPTH),
  localparam int         CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [5:0]    load_data,
  output logic          load_ready,
  input  logic          start,
  input  logic [5:0]    pc,
`ifdef MCCOY_FEEDER_BKPT_EN
  input  logic [5:0]    bkpt_addr,
  input  logic          bkpt_en,
`endif
  output logic [5:0]    instr,
  output logic          running,
  output logic [CW-1:0] count,
  output logic          halted
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_HALT
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [AW-1:0]  wp;
  logic [5:0]     mem [DEPTH];
  logic [5:0]     instr_next;
  logic           transfer;
  logic           bkpt_hit;
  logic           in_range;
  logic [7:0]     pc_wide;
  logic [7:0]     count_wide;

`ifdef MCCOY_FEEDER_BKPT_EN
  assign bkpt_hit = bkpt_en && (pc == bkpt_addr);
  assign halted   = (state == S_HALT);
`else
  assign bkpt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  assign running    = (state == S_RUN);
  assign load_ready = (state == S_LOAD) && (count < CW'(DEPTH));
  // A reset cycle never stores a word, even if a transfer is offered.
  assign transfer   = reset && load_valid && load_ready;

  // Only words below count are valid. Because count never exceeds DEPTH,
  // this one compare also rejects every pc >= DEPTH without wrapping.
  assign pc_wide    = {2'b00, pc};
  assign count_wide = 8'(count);
  assign in_range   = (pc_wide < count_wide);

  // Next-state and fetch selection.
  always_comb begin
    // NOTE: every variable gets a default before the case, so a missing
    // branch keeps its default value and cannot infer a latch.
    state_next = state;
    instr_next = FILL;
    case (state)
      S_LOAD: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        if (bkpt_hit) begin
          state_next = S_HALT;
        end else if (in_range) begin
          instr_next = mem[pc[AW-1:0]];
        end
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: state_next = S_LOAD;
    endcase
  end

  // State, write pointer, count and the registered instruction word.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples the values from before the edge.
    if (!reset) begin
      state <= S_LOAD;
      wp    <= '0;
      count <= '0;
      instr <= FILL;
    end else begin
      state <= state_next;
      instr <= instr_next;
      if (transfer) begin
        wp    <= wp + 1'b1;
        count <= count + 1'b1;
      end
    end
  end

  // Program store write port.
  always_ff @(posedge clk) begin
    // NOTE: the store has no reset. Zeroing count hides the old words,
    // which lets the array map onto plain RAM.
    if (transfer) mem[wp] <= load_data;
  end

endmodule

// File: tb/tb_mccoy_prog_feeder.sv
// Self-checking bench for mccoy_prog_feeder (DEPTH=16, FILL=0). The
// reference model holds the program as a queue of accepted words and a
// run/halt flag. Every cycle it predicts instr, running, halted, count and
// load_ready.
module tb_mccoy_prog_feeder;

  localparam int         DEPTH = 16;
  localparam logic [5:0] FILL  = 6'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [5:0] load_data;
  logic       load_ready;
  logic       start;
  logic [5:0] pc;
  logic [5:0] bkpt_addr;
  logic       bkpt_en;
  logic [5:0] instr;
  logic       running;
  logic [4:0] count;
  logic       halted;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state.
  logic [5:0] prog[$];
  bit         m_run  = 1'b0;
  bit         m_halt = 1'b0;

  mccoy_prog_feeder #(.DEPTH(DEPTH), .FILL(FILL)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .start      (start),
    .pc         (pc),
`ifdef MCCOY_FEEDER_BKPT_EN
    .bkpt_addr  (bkpt_addr),
    .bkpt_en    (bkpt_en),
`endif
    .instr      (instr),
    .running    (running),
    .count      (count),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic idle();
    reset = 1'b1; load_valid = 1'b0; load_data = 6'h00; start = 1'b0;
    pc = 6'h00; bkpt_en = 1'b0; bkpt_addr = 6'h00;
  endtask

  // Advance one clock with the current inputs, update the model, and compare.
  task automatic cycle();
    logic [5:0] e_instr;
    bit         hit;
`ifdef MCCOY_FEEDER_BKPT_EN
    hit = m_run && bkpt_en && (pc == bkpt_addr);
`else
    hit = 1'b0;
`endif
    if (!reset) begin
      prog.delete();
      m_run = 1'b0; m_halt = 1'b0; e_instr = FILL;
    end else begin
      e_instr = (m_run && !hit && (int'(pc) < prog.size())) ? prog[pc] : FILL;
      if (!m_run && !m_halt) begin
        if (load_valid && prog.size() < DEPTH) prog.push_back(load_data);
        if (start) m_run = 1'b1;
      end else if (m_run && hit) begin
        m_run = 1'b0; m_halt = 1'b1;
      end
    end
    @(posedge clk); #1;
    check("instr",      32'(instr),      32'(e_instr));
    check("running",    32'(running),    32'(m_run));
    check("halted",     32'(halted),     32'(m_halt));
    check("count",      32'(count),      32'(prog.size()));
    check("load_ready", 32'(load_ready),
          32'(!m_run && !m_halt && prog.size() < DEPTH));
  endtask

  task automatic do_reset();
    idle(); reset = 1'b0; cycle(); reset = 1'b1;
  endtask

  task automatic load_word(input logic [5:0] w);
    load_valid = 1'b1; load_data = w; cycle(); load_valid = 1'b0;
  endtask

  task automatic fetch(input logic [5:0] a);
    pc = a; cycle();
  endtask

  initial begin
    logic [5:0] first_word;
    idle();

    // Power-on reset state.
    do_reset();
    check("rst_load_ready", 32'(load_ready), 32'd1);

    // Three words, start, and a fetch of each.
    load_word(6'h05); load_word(6'h1A); load_word(6'h3F);
    start = 1'b1; cycle(); start = 1'b0;
    fetch(6'd0); check("basic_w0", 32'(instr), 32'h05);
    fetch(6'd1); check("basic_w1", 32'(instr), 32'h1A);
    fetch(6'd2); check("basic_w2", 32'(instr), 32'h3F);
    check("basic_count", 32'(count), 32'd3);

    // Hold load_valid for 20 cycles: the store fills at 16 and ignores the rest.
    do_reset();
    first_word = 6'(1 + $urandom_range(0, 62));
    load_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      load_data = (i == 0) ? first_word : 6'($urandom);
      cycle();
    end
    load_valid = 1'b0;
    check("full_count", 32'(count), 32'd16);
    check("full_ready", 32'(load_ready), 32'd0);
    start = 1'b1; cycle(); start = 1'b0;
    fetch(6'd0); check("full_w0", 32'(instr), 32'(first_word));

    // pc at count and far above DEPTH both fetch FILL.
    do_reset();
    load_word(6'h11); load_word(6'h22);
    start = 1'b1; cycle(); start = 1'b0;
    fetch(6'd2);  check("oor_pc2",  32'(instr), 32'(FILL));
    fetch(6'd45); check("oor_pc45", 32'(instr), 32'(FILL));

    // Reset mid-RUN, then start with an empty store.
    reset = 1'b0; cycle(); reset = 1'b1;
    check("rerst_running", 32'(running), 32'd0);
    check("rerst_ready",   32'(load_ready), 32'd1);
    start = 1'b1; cycle(); start = 1'b0;
    fetch(6'd0); check("empty_pc0", 32'(instr), 32'(FILL));

    // A word offered in the same cycle as start is still stored.
    do_reset();
    load_valid = 1'b1; load_data = 6'h2B; start = 1'b1; cycle();
    load_valid = 1'b0; start = 1'b0;
    check("same_cyc_count",   32'(count),   32'd1);
    check("same_cyc_running", 32'(running), 32'd1);
    fetch(6'd0); check("same_cyc_w0", 32'(instr), 32'h2B);

`ifdef MCCOY_FEEDER_BKPT_EN
    // Breakpoint at address 2 halts the feeder.
    do_reset();
    for (int i = 0; i < 4; i++) load_word(6'(8 + i));
    start = 1'b1; cycle(); start = 1'b0;
    bkpt_addr = 6'd2; bkpt_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch(6'(i));
      if (i >= 2) check("bkpt_halted", 32'(halted), 32'd1);
    end
    bkpt_en = 1'b0;
`endif

    // Randomized sessions checked against the model.
    for (int s = 0; s < 40; s++) begin
      do_reset();
      for (int i = 0, n = $urandom_range(0, 22); i < n; i++) begin
        load_valid = ($urandom_range(0, 3) != 0);
        load_data  = 6'($urandom);
        start      = (i == n - 1) && ($urandom_range(0, 1) == 1);
        cycle();
      end
      load_valid = 1'b0;
      start = 1'b1; cycle(); start = 1'b0;
      for (int i = 0; i < 14; i++) begin
        pc = ($urandom_range(0, 4) == 0) ? 6'($urandom)
                                         : 6'($urandom_range(0, DEPTH + 1));
        load_valid = ($urandom_range(0, 3) == 0);
        load_data  = 6'($urandom);
        start      = ($urandom_range(0, 3) == 0);
        bkpt_en    = ($urandom_range(0, 5) == 0);
        bkpt_addr  = 6'($urandom_range(0, DEPTH - 1));
        reset      = ($urandom_range(0, 29) != 0);
        cycle();
        reset = 1'b1;
      end
      idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mccoy_prog_feeder.md
MCCOY_PROG_FEEDER -- requirements
Module: mccoy_prog_feeder

Interface
REQ-001 Parameter DEPTH, default 16: program store entries; power of two, 2..64.
REQ-002 Parameter FILL, default 6'b000000: instruction word driven when no valid program word applies.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 load_valid  input  1  program word offered on load_data.
REQ-006 load_data  input  6  program word {reg/imm[2:0], opcode[2:0]}.
REQ-007 load_ready  output  1  feeder accepts a program word this cycle.
REQ-008 start  input  1  request to leave LOAD and begin RUN.
REQ-009 pc  input  6  core program counter.
REQ-010 instr  output  6  registered instruction word to the core's instr field.
REQ-011 running  output  1  high in RUN.
REQ-012 count  output  log2(DEPTH)+1  number of words loaded, saturating at DEPTH.
REQ-013 halted  output  1  high in HALT.

Function
REQ-014 FSM states: LOAD, RUN, HALT; reset enters LOAD.
REQ-015 LOAD: load_ready SHALL equal (count < DEPTH); otherwise 0.
REQ-016 Transfer occurs on a cycle with load_valid && load_ready; the word is written at write pointer wp, then wp increments and count increments.
REQ-017 Full: once count==DEPTH, load_ready=0, load_data is ignored, and no entry is overwritten.
REQ-018 LOAD->RUN on start=1; a transfer in the same cycle is still written.
REQ-019 start with count==0 SHALL still enter RUN; every fetch then returns FILL.
REQ-020 RUN: instr is updated each cycle to mem[pc] when pc < count, else FILL; latency 1 clk from pc to instr.
REQ-021 pc >= DEPTH SHALL return FILL; the address does not wrap.
REQ-022 In LOAD and HALT, instr SHALL hold FILL.
REQ-023 start is ignored in RUN and HALT; only reset returns to LOAD.
REQ-024 Memory contents are not cleared by reset; reset only zeroes count and wp, so old words are unreachable.
REQ-025 RUN->HALT only via the breakpoint feature (REQ-030); otherwise RUN is terminal until reset.

Reset
REQ-026 reset=0 at a rising edge: state=LOAD, wp=0, count=0, instr=FILL, running=0, halted=0, load_ready=1 on the next cycle.
REQ-027 Reset SHALL take priority over transfers, start, and breakpoint hits in the same cycle.
REQ-028 Reset mid-RUN or mid-HALT SHALL behave identically to power-on reset.

Configuration
REQ-029 Macro MCCOY_FEEDER_BKPT_EN selects the breakpoint feature.
REQ-030 With MCCOY_FEEDER_BKPT_EN defined, the block SHALL add the following:
  - input bkpt_addr (6 bits) and input bkpt_en (1 bit);
  - in RUN, when bkpt_en=1 and pc==bkpt_addr, instr becomes FILL instead of mem[pc];
  - on that same edge the state goes to HALT; halted=1 from the next cycle.
REQ-031 Without the macro, those ports do not exist, halted is tied 0, and HALT is unreachable.

Verification
REQ-032 Reset, load 6'h05,6'h1A,6'h3F (valid each cycle), start, then pc=0,1,2 -> instr=05,1A,3F one cycle after each pc; running=1; count=3.
REQ-033 Hold load_valid for 20 cycles with DEPTH=16 -> count=16, load_ready=0 from the cycle after the 16th transfer; word 17 is never stored (pc=0 still returns the first word).
REQ-034 Load 2 words, start, pc=2 and pc=45 -> instr=FILL (6'h00) for both.
REQ-035 In RUN, assert reset=0 for one cycle -> running=0, count=0, instr=FILL, load_ready=1; start then gives FILL for pc=0.
REQ-036 With MCCOY_FEEDER_BKPT_EN: load 4 words, bkpt_addr=2, bkpt_en=1, step pc 0..3 -> words 0,1 then FILL; halted=1 from the cycle after pc=2; instr stays FILL for pc=3.
REQ-037 Assert load_valid and start in the same cycle with count=0 -> the word is stored, count=1, running=1 next cycle.
